// File: rtl/mem_copy_dma_if.sv
// Data-memory port driven by the copy/fill engine.
// master = engine side, slave = memory side.
interface mem_copy_dma_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Block copy / constant fill engine for the single-port data memory.
// All outputs are registered; next values are derived from the next state.
module mem_copy_dma #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill_mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              abort,
    mem_copy_dma_if.master    mem,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] fval_q, fval_d;
    logic              mode_q, mode_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        words_d     = words_q;
        data_d      = data_q;
        fval_d      = fval_q;
        mode_d      = mode_q;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wr_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = length;
                    mode_d  = fill_mode;
                    fval_d  = fill_value;
                    words_d = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (fill_mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_DONE;
                end else begin
                    data_d  = mem.mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                src_d   = src_q + ADDR_W'(1);
                dst_d   = dst_q + ADDR_W'(1);
                rem_d   = rem_q - LEN_W'(1);
                words_d = words_q + LEN_W'(1);
                if (rem_q == LEN_W'(1) || abort) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_READ: begin
                mem_addr_d = src_d;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                mem_addr_d  = dst_d;
                mem_wr_d    = 1'b1;
                mem_wdata_d = mode_d ? fval_d : data_d;
                busy_d      = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            words_q     <= '0;
            data_q      <= '0;
            fval_q      <= '0;
            mode_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            words_q     <= words_d;
            data_q      <= data_d;
            fval_q      <= fval_d;
            mode_q      <= mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wr    = mem_wr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_done    = words_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: 256-word memory model plus a word-level
// reference of what each copy/fill/abort must write and when done comes.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        fill_mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
    logic [31:0] fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] words_done;

    mem_copy_dma_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_copy_dma #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fill_mode  (fill_mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .abort      (abort),
        .mem        (bus),
        .busy       (busy),
        .done       (done),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] rdata;
    int          wr_cnt = 0;
    logic [31:0] log_a [1024];
    logic [31:0] log_d [1024];
    int          errors = 0;
    int          checks = 0;

    assign bus.mem_rdata = rdata;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    always @(negedge clk) begin
        rdata <= mem[bus.mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            log_a[wr_cnt[9:0]] <= bus.mem_addr;
            log_d[wr_cnt[9:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input string tag, input bit fm,
                           input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] len, input logic [31:0] fv,
                           input int ab, input bit poke);
        int L;
        int nexp;
        int latexp;
        int lat;
        int hi;
        int base;
        logic [31:0] a;
        logic [31:0] sa;
        logic [31:0] v;
        L = int'(len);
        if (L == 0) begin
            nexp = 0;
            latexp = 1;
        end else if (fm) begin
            if (ab >= 1 && ab <= L) begin
                nexp = ab;
                latexp = ab + 1;
            end else begin
                nexp = L;
                latexp = L + 1;
            end
        end else begin
            if (ab >= 1 && ab <= 2 * L) begin
                nexp = ab / 2;
                latexp = ab + 1;
            end else begin
                nexp = L;
                latexp = 2 * L + 1;
            end
        end
        base = wr_cnt;
        @(negedge clk);
        fill_mode = fm;
        src_addr = s;
        dst_addr = d;
        length = len;
        fill_value = fv;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        hi = 0;
        for (int c = 1; c <= 2 * L + 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) hi++;
            start = poke && (c == 2);
            if (poke && c == 2) begin
                src_addr = ~s;
                dst_addr = ~d;
                length = len + 16'd5;
                fill_mode = ~fm;
            end
            abort = (c == ab);
        end
        start = 1'b0;
        abort = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(latexp));
        check({tag, ".busy_cycles"}, 64'(hi), 64'(latexp - 1));
        check({tag, ".words_done"}, 64'(words_done), 64'(nexp));
        check({tag, ".writes"}, 64'(wr_cnt - base), 64'(nexp));
        for (int k = 0; k < nexp; k++) begin
            a = d + 32'(k);
            sa = s + 32'(k);
            v = fm ? fv : ref_mem[sa[7:0]];
            ref_mem[a[7:0]] = v;
            check($sformatf("%s.wr%0d", tag, k),
                  {log_a[(base + k) % 1024], log_d[(base + k) % 1024]},
                  {a, v});
        end
        @(negedge clk);
        check({tag, ".done_width"}, 64'({done, busy}), 64'(0));
        check({tag, ".words_hold"}, 64'(words_done), 64'(nexp));
    endtask

    initial begin
        int seen;
        int base;
        int mism;
        bit fm;
        int L;
        int ab;
        rst = 1'b0;
        start = 1'b0;
        fill_mode = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length = '0;
        fill_value = '0;
        abort = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        #3;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.words_done", 64'(words_done), 64'(0));
        check("reset.mem_wr", 64'(bus.mem_wr), 64'(0));
        check("reset.mem_addr", 64'(bus.mem_addr), 64'(0));
        check("reset.mem_wdata", 64'(bus.mem_wdata), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            @(negedge clk);
            load_en = 1'b1;
            load_addr = 8'(i);
            load_data = ref_mem[i];
        end
        @(negedge clk);
        load_en = 1'b0;

        do_xfer("copy4", 1'b0, 32'd10, 32'd100, 16'd4, 32'h0, 0, 1'b0);
        do_xfer("fill3", 1'b1, 32'd0, 32'd20, 16'd3, 32'hDEADBEEF, 0, 1'b0);
        do_xfer("copy_len0", 1'b0, 32'd5, 32'd110, 16'd0, 32'h0, 0, 1'b0);
        do_xfer("fill_len0", 1'b1, 32'd0, 32'd115, 16'd0, 32'h1234, 0, 1'b0);
        do_xfer("abort_rd2", 1'b0, 32'd30, 32'd160, 16'd8, 32'h0, 3, 1'b0);
        do_xfer("abort_wr2", 1'b0, 32'd30, 32'd170, 16'd8, 32'h0, 4, 1'b0);
        do_xfer("abort_fill", 1'b1, 32'd0, 32'd180, 16'd6, 32'hA5A5, 2, 1'b0);
        do_xfer("wrap_fill", 1'b1, 32'd0, 32'hFFFFFFFF, 16'd2, $urandom, 0,
                1'b0);
        do_xfer("wrap_copy", 1'b0, 32'hFFFFFFFE, 32'd60, 16'd3, 32'h0, 0,
                1'b0);
        do_xfer("start_busy", 1'b0, 32'd50, 32'd200, 16'd5, 32'h0, 0, 1'b1);
        do_xfer("overlap", 1'b0, 32'd70, 32'd72, 16'd6, 32'h0, 0, 1'b0);

        for (int t = 0; t < 10; t++) begin
            fm = 1'($urandom_range(0, 1));
            L = int'($urandom_range(0, 10));
            ab = 0;
            if (L > 0 && $urandom_range(0, 2) == 0) begin
                ab = int'($urandom_range(1, fm ? L : 2 * L));
            end
            do_xfer($sformatf("rand%0d", t), fm, $urandom, $urandom,
                    16'(L), $urandom, ab, 1'($urandom_range(0, 1)));
        end

        base = wr_cnt;
        @(negedge clk);
        fill_mode = 1'b0;
        src_addr = 32'd40;
        dst_addr = 32'd140;
        length = 16'd8;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.mem_wr) seen++;
            if (seen == 2) break;
            @(negedge clk);
        end
        check("rst_mid.reach", 64'(seen), 64'(2));
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid.busy", 64'(busy), 64'(0));
        check("rst_mid.mem_wr", 64'(bus.mem_wr), 64'(0));
        check("rst_mid.mem_addr", 64'(bus.mem_addr), 64'(0));
        ref_mem[140] = ref_mem[40];
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid.writes", 64'(wr_cnt - base), 64'(1));
        check("rst_mid.words_done", 64'(words_done), 64'(0));
        check("rst_mid.idle", 64'({busy, done}), 64'(0));

        do_xfer("post_rst", 1'b1, 32'd0, 32'd240, 16'd4, 32'hCAFEF00D, 0,
                1'b0);

        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) mism++;
        end
        check("mem_image", 64'(mism), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
Initiator-side engine for the single-port data memory (combinational read, write on the rising clk edge when the write strobe is high). It copies a block of words from a source region to a destination region, or fills a region with a constant, and drives the memory's address, write-strobe and write-data inputs itself. It sits beside the CPU on the data-memory port. External arbitration muxes the port to the engine while busy is high.

Parameters:
ADDR_W, 32, width of memory word address (memory is word-indexed, consecutive words differ by 1)
DATA_W, 32, memory word width
LEN_W, 16, width of transfer length and progress counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
start  input  1  request a transfer; sampled only in IDLE
fill_mode  input  1  0=copy src->dst, 1=fill dst with fill_value; sampled with start
src_addr  input  ADDR_W  first source word address (ignored in fill mode)
dst_addr  input  ADDR_W  first destination word address
length  input  LEN_W  number of words to transfer
fill_value  input  DATA_W  fill pattern, captured at start
abort  input  1  terminate active transfer early
mem_addr  output  ADDR_W  address to data memory
mem_wr  output  1  write strobe to data memory
mem_wdata  output  DATA_W  write data to data memory
mem_rdata  input  DATA_W  read data from data memory (combinational from mem_addr)
busy  output  1  high in READ/WRITE states
done  output  1  one-cycle pulse at end of every accepted transfer
words_done  output  LEN_W  count of words written in current/last transfer

Behaviour:
- States: IDLE, READ, WRITE, DONE. Reset (rst=0): state=IDLE, all internal registers and words_done=0, busy=0, done=0, mem_wr=0, mem_addr=0, mem_wdata=0. Reset mid-transfer abandons it immediately; no further writes.
- IDLE: start=1 at an edge latches src/dst/length/fill_mode/fill_value and clears words_done. length=0 -> DONE. Otherwise copy -> READ; fill -> WRITE. start in any other state is ignored (no queueing).
- READ (copy only): mem_addr=current src, mem_wr=0. At edge, mem_rdata captured into data register; -> WRITE.
- WRITE: mem_addr=current dst, mem_wr=1, mem_wdata=data register (copy) or fill_value (fill). At edge the memory commits. src and dst increment by 1, remaining decrements, words_done increments. If remaining reaches 0 or abort=1 -> DONE; otherwise -> READ (copy) or WRITE (fill).
- Throughput: copy 2 cycles/word, fill 1 cycle/word. Start-to-done latency for N>0 words: 1+2N cycles (copy) or 1+N cycles (fill) from the start edge to the DONE cycle.
- DONE: done=1, busy=0, mem_wr=0 for exactly one cycle; -> IDLE.
- Outputs registered from state. In IDLE and DONE: mem_addr=0, mem_wdata=0, mem_wr=0.
- abort: only acts in READ/WRITE. In READ -> DONE with no write for that word. In WRITE the current write still commits and counts, then -> DONE. Ignored in IDLE/DONE.
- Address arithmetic modulo 2^ADDR_W: an address of all-ones wraps to 0.
- Overlap: copy is strictly ascending, read-before-write per word. With dst>src inside the source range, already-written words are re-read (defined, not prevented).
- words_done holds its final value after DONE until the next accepted start.

Test Plan:
- Copy 4 words: mem[10..13]=A,B,C,D; start, src=10, dst=100, len=4 -> mem[100..103]=A,B,C,D; done pulses 9 cycles after the start edge; words_done=4; mem_wr high on exactly 4 cycles.
- Fill 3 words: dst=20, fill_value=0xDEADBEEF, len=3 -> mem[20..22]=0xDEADBEEF; done 4 cycles after start; no READ cycles.
- length=0 -> done pulse on the next cycle, mem_wr never asserted, words_done=0.
- Abort during the second READ of an 8-word copy -> exactly 1 word written, words_done=1, done pulse follows. Abort during the second WRITE -> words_done=2.
- Wrap: fill dst=0xFFFFFFFF, len=2 -> writes to 0xFFFFFFFF then 0x00000000.
- rst=0 asserted mid-copy -> busy/mem_wr drop immediately without a clock edge; no further writes. start pulsed while busy -> ignored, and the original transfer completes unchanged.
